mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares the data-side memory bus (BRAM port B, RTC, Peripherals) between the CPU data port and one secondary bus master (DMA/debug loader).
- Owns address decode, per-target enables, the one-cycle read-response steering and the CPU stall, replacing the open-coded decode/mux at SoC top level.
- CPU has fixed priority, backed by an anti-starvation counter that forces a DMA grant.

Parameters:
- STARVE_LIMIT, 8, consecutive cycles a pending DMA request may be refused before it is force-granted (1..255).
- BRAM_TOP, 4'h2, decode: addr[31:28] < BRAM_TOP selects BRAM.
- RTC_TOP, 4'h8, decode: BRAM_TOP <= addr[31:28] < RTC_TOP selects RTC; anything else selects Peripherals.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-low reset
- cpu_en_i  in  1  CPU data access request (mem_operation_enable)
- cpu_we_i  in  4  CPU byte write enables, 0 = read
- cpu_addr_i  in  32  CPU data address
- cpu_data_i  in  32  CPU write data
- cpu_data_o  out  32  read data returned to CPU
- cpu_stall_o  out  1  CPU stall: arbitration loss OR per_stall_i
- dma_req_i  in  1  DMA request, held until dma_gnt_o
- dma_we_i  in  4  DMA byte write enables
- dma_addr_i  in  32  DMA address
- dma_data_i  in  32  DMA write data
- dma_gnt_o  out  1  DMA request accepted this cycle
- dma_rvalid_o  out  1  DMA read data / error valid, one cycle after grant of a read
- dma_err_o  out  1  qualifies dma_rvalid_o: access outside BRAM
- dma_data_o  out  32  DMA read data
- bus_addr_o  out  32  shared target address
- bus_we_o  out  4  shared byte write enables
- bus_data_o  out  32  shared write data
- bram_en_o  out  1  BRAM port B enable
- bram_data_i  in  32  BRAM read data (1-cycle latency)
- rtc_en_o  out  1  RTC enable
- rtc_data_i  in  32  RTC read data (1-cycle latency)
- per_en_o  out  1  Peripherals enable
- per_data_i  in  32  Peripherals read data (1-cycle latency)
- per_stall_i  in  1  Peripherals stall request

Behaviour:
- Reset (reset=0, async): all enables, dma_gnt_o, dma_rvalid_o, dma_err_o, cpu_stall_o = 0; cpu_data_o, dma_data_o = 0; starve counter = 0; response tag = NONE.
- Arbitration is combinational each cycle. Owner = DMA if dma_req_i && (!cpu_en_i || starve_cnt == STARVE_LIMIT); else CPU if cpu_en_i; else none.
- DMA owner: bus_* = dma_*. dma_gnt_o = 1.
  - DMA address decodes to BRAM: bram_en_o = 1.
  - Otherwise: no target enable is raised; the access becomes an error.
  - cpu_stall_o = 1 when cpu_en_i is also high. The CPU holds its request; it is served next cycle.
- CPU owner: bus_* = cpu_*. Exactly one of bram/rtc/per_en_o is raised, per decode.
- No owner: all enables = 0; bus_* = CPU fields.
- Starve counter:
  - Increments when dma_req_i && !dma_gnt_o, saturating at STARVE_LIMIT.
  - Clears on any dma_gnt_o or when !dma_req_i.
- Response tag, registered every cycle. Values: NONE, CPU_BRAM, CPU_RTC, CPU_PER, DMA_OK, DMA_ERR.
  - DMA_OK / DMA_ERR are tagged only for DMA reads. DMA writes produce no rvalid; a DMA write outside BRAM is dropped silently.
  - CPU writes still tag their target.
- Cycle after access:
  - cpu_data_o = BRAM/RTC/PER data per tag.
  - dma_rvalid_o = 1 for DMA_OK / DMA_ERR, with dma_data_o = bram_data_i (OK) or 32'h0 (ERR); dma_err_o = 1 for DMA_ERR.
  - When the tag is not CPU_*, cpu_data_o holds its previous value.
- per_stall_i: ORed into cpu_stall_o; blocks no DMA grant.
- Simultaneous cpu_en_i and dma_req_i with count < STARVE_LIMIT: CPU wins; counter increments.
- Back-to-back DMA: granted every cycle while the CPU is idle; one rvalid per granted read, in order.
- Reset mid-access: pending response tag discarded; no rvalid is produced after reset release.

Optional Feature:
- MEM_ARB_STATS_EN defined: adds outputs stat_stall_o[31:0] and stat_dma_grants_o[31:0].
  - stat_stall_o counts cycles with cpu_stall_o caused by arbitration (not per_stall_i).
  - stat_dma_grants_o counts dma_gnt_o pulses.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- CPU read 0x0000_0010, BRAM returns 0xDEADBEEF, DMA idle -> bram_en_o=1 for 1 cycle; next cycle cpu_data_o=0xDEADBEEF; cpu_stall_o=0.
- CPU read 0x8000_0000 with per_stall_i high for 3 cycles -> per_en_o=1, cpu_stall_o=1 for 3 cycles, rtc_en_o/bram_en_o stay 0.
- DMA read 0x0000_0100 while CPU idle, BRAM returns 0x12345678 -> dma_gnt_o same cycle; next cycle dma_rvalid_o=1, dma_err_o=0, dma_data_o=0x12345678.
- CPU requesting every cycle + dma_req_i held, STARVE_LIMIT=8 -> 8 CPU grants, 9th cycle dma_gnt_o=1 and cpu_stall_o=1, counter back to 0.
- DMA read 0x4000_0000 -> dma_gnt_o=1, no target enable; next cycle dma_rvalid_o=1, dma_err_o=1, dma_data_o=0.
- DMA read granted, reset asserted before next edge -> after release dma_rvalid_o stays 0, all enables 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Data-side memory bus arbiter: CPU (fixed priority) vs one DMA/debug master, with decode and read steering.
// Optional MEM_ARB_STATS_EN adds stall and DMA-grant statistic counters.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter logic [3:0]  BRAM_TOP     = 4'h2,
    parameter logic [3:0]  RTC_TOP      = 4'h8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en_i,
    input  logic [3:0]  cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        cpu_stall_o,
    input  logic        dma_req_i,
    input  logic [3:0]  dma_we_i,
    input  logic [31:0] dma_addr_i,
    input  logic [31:0] dma_data_i,
    output logic        dma_gnt_o,
    output logic        dma_rvalid_o,
    output logic        dma_err_o,
    output logic [31:0] dma_data_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_we_o,
    output logic [31:0] bus_data_o,
    output logic        bram_en_o,
    input  logic [31:0] bram_data_i,
    output logic        rtc_en_o,
    input  logic [31:0] rtc_data_i,
    output logic        per_en_o,
    input  logic [31:0] per_data_i,
    input  logic        per_stall_i
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0] stat_stall_o,
    output logic [31:0] stat_dma_grants_o
`endif
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        TAG_NONE, TAG_CPU_BRAM, TAG_CPU_RTC, TAG_CPU_PER, TAG_DMA_OK, TAG_DMA_ERR
    } tag_t;

    typedef enum logic [1:0] {TGT_BRAM, TGT_RTC, TGT_PER} tgt_t;

    function automatic tgt_t decode(input logic [31:0] a);
        if (a[31:28] < BRAM_TOP)     return TGT_BRAM;
        else if (a[31:28] < RTC_TOP) return TGT_RTC;
        else                         return TGT_PER;
    endfunction

    logic [7:0]  starve_cnt;
    tag_t        tag, tag_nxt;
    tgt_t        cpu_tgt, dma_tgt;
    logic        dma_own, cpu_own, arb_stall;
    logic [31:0] cpu_data_q, resp_data;
    logic        tag_is_cpu;

    // Grant and enable outputs are forced low while reset is held, not just after the first edge.
    always_comb begin
        cpu_tgt   = decode(cpu_addr_i);
        dma_tgt   = decode(dma_addr_i);
        dma_own   = reset && dma_req_i && (!cpu_en_i || starve_cnt == LIMIT);
        cpu_own   = reset && cpu_en_i && !dma_own;
        arb_stall = dma_own && cpu_en_i;

        bus_addr_o = dma_own ? dma_addr_i : cpu_addr_i;
        bus_we_o   = dma_own ? dma_we_i   : cpu_we_i;
        bus_data_o = dma_own ? dma_data_i : cpu_data_i;

        bram_en_o   = (dma_own && dma_tgt == TGT_BRAM) || (cpu_own && cpu_tgt == TGT_BRAM);
        rtc_en_o    = cpu_own && cpu_tgt == TGT_RTC;
        per_en_o    = cpu_own && cpu_tgt == TGT_PER;
        dma_gnt_o   = dma_own;
        cpu_stall_o = reset && (arb_stall || per_stall_i);

        tag_nxt = TAG_NONE;
        if (dma_own) begin
            // DMA writes never produce a response, even when they miss BRAM.
            if (dma_we_i == 4'h0)
                tag_nxt = (dma_tgt == TGT_BRAM) ? TAG_DMA_OK : TAG_DMA_ERR;
        end else if (cpu_own) begin
            case (cpu_tgt)
                TGT_BRAM: tag_nxt = TAG_CPU_BRAM;
                TGT_RTC:  tag_nxt = TAG_CPU_RTC;
                default:  tag_nxt = TAG_CPU_PER;
            endcase
        end
    end

    always_comb begin
        tag_is_cpu = 1'b1;
        resp_data  = cpu_data_q;
        case (tag)
            TAG_CPU_BRAM: resp_data = bram_data_i;
            TAG_CPU_RTC:  resp_data = rtc_data_i;
            TAG_CPU_PER:  resp_data = per_data_i;
            default:      tag_is_cpu = 1'b0;
        endcase
    end

    assign cpu_data_o   = resp_data;
    assign dma_rvalid_o = (tag == TAG_DMA_OK) || (tag == TAG_DMA_ERR);
    assign dma_err_o    = (tag == TAG_DMA_ERR);
    assign dma_data_o   = (tag == TAG_DMA_OK) ? bram_data_i : 32'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag        <= TAG_NONE;
            cpu_data_q <= 32'h0;
            starve_cnt <= 8'h0;
        end else begin
            tag <= tag_nxt;
            if (tag_is_cpu)
                cpu_data_q <= resp_data;
            if (!dma_req_i || dma_own)
                starve_cnt <= 8'h0;
            else if (starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 8'h1;
        end
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_stall_o      <= 32'h0;
            stat_dma_grants_o <= 32'h0;
        end else begin
            if (arb_stall) stat_stall_o      <= stat_stall_o + 32'h1;
            if (dma_own)   stat_dma_grants_o <= stat_dma_grants_o + 32'h1;
        end
    end
`endif

endmodule
